tick_generator: RTL and testbench

Parametrised multi-channel tick generator replacing the fixed 1 Hz / 500 ms divider. Each of N_CH channels divides the system clock by an independently runtime-programmable divisor and emits a one-cycle period tick, a one-cycle mid-period tick and a square wave. Divisor updates go through a valid/ready port and take effect glitch-free at a period boundary. Consumers are the clock/timekeeping counters, display blink logic and button-repeat timers.

---
 rtl/tick_generator.sv | 107 ++++++++++
 tb/tb_tick_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: per-channel period tick, mid-period tick
// and square wave, with divisor updates committed only at period boundaries.
module tick_generator #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 100_000_000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  half,
    output logic [N_CH-1:0]  sq
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    logic             pend_valid_reg;
    logic [CH_W-1:0]  pend_ch_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             cfg_ready_reg;
    logic [N_CH-1:0]  commit_vec;
    logic             ch_ok;
    logic             accept;

    assign ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
    assign accept    = cfg_valid && cfg_ready_reg && ch_ok;
    assign cfg_ready = cfg_ready_reg;

    // Ready stays low for one extra cycle after the commit edge, so it is a
    // pure register and never a path from the channel state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_reg <= 1'b0;
            pend_ch_reg    <= '0;
            pend_div_reg   <= DEF_DIV;
            cfg_ready_reg  <= 1'b1;
        end else begin
            cfg_ready_reg <= !pend_valid_reg && !accept;
            if (accept) begin
                pend_valid_reg <= 1'b1;
                pend_ch_reg    <= cfg_ch;
                pend_div_reg   <= (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
            end else if (|commit_vec) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] div_reg;
        logic             tick_reg;
        logic             half_reg;
        logic             sq_reg;
        logic [CNT_W-1:0] half_div;
        logic [CNT_W-1:0] cnt_next;
        logic             wrap;
        logic             mid;

        assign half_div = div_reg >> 1;
        assign wrap     = (cnt_reg == div_reg - CNT_W'(1));
        assign mid      = (cnt_reg == half_div - CNT_W'(1));
        assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);

        // Commit only at a period boundary: wrap, disable or sync.
        assign commit_vec[gi] = pend_valid_reg && (pend_ch_reg == CH_W'(gi)) &&
                                (!en[gi] || sync || wrap);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg  <= '0;
                div_reg  <= DEF_DIV;
                tick_reg <= 1'b0;
                half_reg <= 1'b0;
                sq_reg   <= 1'b0;
            end else begin
                if (commit_vec[gi]) begin
                    div_reg <= pend_div_reg;
                end
                if (!en[gi] || sync) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                    half_reg <= 1'b0;
                    sq_reg   <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    tick_reg <= wrap;
                    half_reg <= mid;
                    sq_reg   <= (cnt_next >= half_div);
                end
            end
        end

        assign tick[gi] = tick_reg;
        assign half[gi] = half_reg;
        assign sq[gi]   = sq_reg;
    end

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: expected tick/half edges are queued per channel
// and a negedge monitor pops and compares them as pulses appear.
module tb_tick_generator;

    localparam int N_CH  = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  half;
    logic [N_CH-1:0]  sq;

    int cyc    = 0;
    int t0     = 0;
    int errors = 0;
    int checks = 0;
    int exp_q [N_CH][2][$];

    tick_generator #(
        .N_CH(N_CH),
        .CNT_W(CNT_W),
        .DEFAULT_DIV(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sync(sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .tick(tick),
        .half(half),
        .sq(sq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_to(input int e);
        while ((cyc - t0) < e) @(negedge clk);
    endtask

    task automatic expect_train(input int c, input int k, input int first, input int step, input int last);
        for (int e = first; e <= last; e += step) exp_q[c][k].push_back(e);
    endtask

    task automatic cfg_write(input int c, input int d);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(c);
        cfg_div   = CNT_W'(d);
        $display("cfg write ch=%0d div=%0d before edge %0d", c, d, cyc - t0 + 1);
    endtask

    task automatic mon_one(input int c, input int k, input logic v, input int rel);
        string nm;
        nm = $sformatf("%s[%0d]", (k == 0) ? "tick" : "half", c);
        if (v) begin
            if (exp_q[c][k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected: got pulse at edge %0d expected none", nm, rel);
            end else begin
                int e;
                e = exp_q[c][k].pop_front();
                check({nm, " edge"}, rel, e);
            end
        end else if (exp_q[c][k].size() > 0 && exp_q[c][k][0] < rel) begin
            int e;
            e = exp_q[c][k].pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing: got no pulse expected pulse at edge %0d", nm, e);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        for (int c = 0; c < N_CH; c++) begin
            mon_one(c, 0, tick[c], rel);
            mon_one(c, 1, half[c], rel);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en        = '0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        repeat (3) @(negedge clk);
        check("reset tick", tick, 0);
        check("reset half", half, 0);
        check("reset sq", sq, 0);
        check("reset cfg_ready", cfg_ready, 1);

        // Default D=10 on channels 0 and 1; channel 1 reprogrammed to 4 mid-period.
        en    = 3'b011;
        rst_n = 1'b1;
        t0    = cyc;
        expect_train(0, 0, 10, 10, 60);
        expect_train(0, 1, 5, 10, 55);
        expect_train(1, 0, 10, 10, 40);
        expect_train(1, 0, 44, 4, 60);
        expect_train(1, 1, 5, 10, 35);
        expect_train(1, 1, 42, 4, 58);
        for (int e = 1; e <= 12; e++) begin
            run_to(e);
            check($sformatf("sq0 edge %0d", e), sq[0], ((e % 10) >= 5));
            check($sformatf("sq1 edge %0d", e), sq[1], ((e % 10) >= 5));
        end
        run_to(33);
        cfg_write(1, 4);
        run_to(34);
        cfg_valid = 1'b0;
        check("ready after accept", cfg_ready, 0);
        run_to(40);
        check("ready at commit", cfg_ready, 0);
        run_to(41);
        check("ready after commit", cfg_ready, 1);
        run_to(60);
        en = '0;

        // Divisor 0 to a disabled channel clamps to 2 and commits at once.
        run_to(62);
        cfg_write(0, 0);
        run_to(63);
        cfg_valid = 1'b0;
        check("ready disabled accept", cfg_ready, 0);
        run_to(64);
        check("ready disabled commit", cfg_ready, 0);
        run_to(65);
        check("ready disabled back", cfg_ready, 1);
        run_to(66);
        en = 3'b001;
        expect_train(0, 0, 68, 2, 72);
        expect_train(0, 1, 67, 2, 71);
        run_to(67);
        check("sq0 D2 odd", sq[0], 1);
        run_to(68);
        check("sq0 D2 even", sq[0], 0);
        run_to(72);
        en = '0;

        // D=7 and D=10, sync on the edge where channel 0 would wrap.
        run_to(74);
        cfg_write(0, 7);
        run_to(75);
        cfg_valid = 1'b0;
        run_to(77);
        cfg_write(1, 10);
        run_to(78);
        cfg_valid = 1'b0;
        run_to(79);
        check("ready ch1 commit", cfg_ready, 0);
        run_to(80);
        check("ready ch1 back", cfg_ready, 1);
        run_to(82);
        en = 3'b011;
        expect_train(0, 0, 89, 7, 96);
        expect_train(0, 1, 85, 7, 99);
        expect_train(1, 0, 92, 10, 102);
        expect_train(1, 1, 87, 10, 97);
        run_to(102);
        sync = 1'b1;
        run_to(103);
        sync = 1'b0;
        check("sq after sync", sq, 0);
        expect_train(0, 0, 110, 7, 131);
        expect_train(0, 1, 106, 7, 127);
        expect_train(1, 0, 113, 10, 123);
        expect_train(1, 1, 108, 10, 128);

        // Out-of-range channel: accepted, discarded, ready never drops.
        run_to(117);
        cfg_write(3, 5);
        run_to(118);
        cfg_valid = 1'b0;
        check("ready bad ch", cfg_ready, 1);
        run_to(119);
        check("ready bad ch next", cfg_ready, 1);

        // Reset mid-period with an update pending.
        run_to(130);
        cfg_write(1, 3);
        run_to(131);
        cfg_valid = 1'b0;
        check("ready pending", cfg_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tick", tick, 0);
        check("async reset half", half, 0);
        check("async reset sq", sq, 0);
        check("async reset cfg_ready", cfg_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0    = cyc;
        expect_train(0, 0, 10, 10, 20);
        expect_train(0, 1, 5, 10, 15);
        expect_train(1, 0, 10, 10, 20);
        expect_train(1, 1, 5, 10, 15);
        run_to(22);
        check("final cfg_ready", cfg_ready, 1);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("tick[%0d] leftover", c), exp_q[c][0].size(), 0);
            check($sformatf("half[%0d] leftover", c), exp_q[c][1].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
